// File: rtl/accumulator_pkg.sv
// Shared definitions for the term collector and its downstream accumulator:
// the collector state encoding and the common term-width calculation.
package accumulator_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } collector_state_e;

    // Width that holds the sum of num_elements maximal word_len-bit words
    function automatic int calc_bit_len(input int word_len, input int num_elements);
        return word_len + $clog2(num_elements);
    endfunction

endpackage

// File: rtl/accumulator.sv
// Adder tree over a packed frame of terms; the sum is registered when the
// producer's frame is handed over (load high).
module accumulator
    import accumulator_pkg::*;
#(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = calc_bit_len(16, NUM_ELEMENTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
    output logic [BIT_LEN-1:0] sum
);

    logic [BIT_LEN-1:0] sum_s;
    logic [BIT_LEN-1:0] sum_r;

    // Combinational sum of all slots
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            sum_s = sum_s + terms[k];
        end
    end

    // Capture the sum on frame handover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
        end else if (load) begin
            sum_r <= sum_s;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/term_collector.sv
// Serial-to-parallel front end: packs zero-extended input words into a frame
// of terms and holds it stable until the downstream accumulator takes it.
module term_collector
    import accumulator_pkg::*;
#(
    parameter int NUM_ELEMENTS = 9,
    parameter int WORD_LEN     = 16,
    parameter int BIT_LEN      = calc_bit_len(WORD_LEN, NUM_ELEMENTS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WORD_LEN-1:0]                 in_data,
    input  logic                                in_last,
    output logic [BIT_LEN-1:0]                  terms [NUM_ELEMENTS],
    output logic [$clog2(NUM_ELEMENTS+1)-1:0]   out_count,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int IDX_W = $clog2(NUM_ELEMENTS);
    localparam int CNT_W = $clog2(NUM_ELEMENTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    collector_state_e   state_r;
    collector_state_e   state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [BIT_LEN-1:0] terms_r [NUM_ELEMENTS];
    logic               accept_s;
    logic               close_s;
    logic               release_s;

    // Handshake decode and next-state selection
    always_comb begin
        accept_s    = 1'b0;
        close_s     = 1'b0;
        release_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                accept_s = in_valid && in_ready_r;
                close_s  = accept_s && (in_last || (idx_r == LAST_IDX));
                if (close_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                release_s = out_ready;
                if (out_ready) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State, registered handshake flags, slot index and frame count.
    // in_ready stays low through reset and rises on the first clock after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            idx_r       <= '0;
            out_count_r <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == FILL);
            out_valid_r <= (state_nxt_s == HOLD);
            if (release_s) begin
                idx_r       <= '0;
                out_count_r <= '0;
            end else if (accept_s) begin
                idx_r <= idx_r + IDX_W'(1'b1);
                if (close_s) begin
                    out_count_r <= CNT_W'(idx_r) + CNT_W'(1'b1);
                end
            end
        end
    end

    // Term buffer: cleared on release so unused slots of the next frame read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                terms_r[k] <= '0;
            end
        end else if (release_s) begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                terms_r[k] <= '0;
            end
        end else if (accept_s) begin
            terms_r[idx_r] <= {{(BIT_LEN-WORD_LEN){1'b0}}, in_data};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
    assign terms     = terms_r;

endmodule

// File: doc/term_collector.md
# term_collector

Serial-to-parallel front end for the combinational accumulator. It accepts one `WORD_LEN`-bit word per cycle over a valid/ready stream and zero-extends each word to `BIT_LEN`. It packs the words into a `NUM_ELEMENTS`-entry `terms` array and presents the frame, held stable, to the downstream accumulator under a valid/ready handshake. Short frames are closed early with `in_last`; unused slots read as zero, so the downstream sum stays correct.

## Interface
Parameters:
- `NUM_ELEMENTS`, 9: slots per frame; must be ≥ 2.
- `WORD_LEN`, 16: width of each input word.
- `BIT_LEN`, `WORD_LEN + $clog2(NUM_ELEMENTS)`: width of each `terms` entry. Derived; not to be overridden.

Ports:
- `clk` — in, 1: single clock. All state is updated on the rising edge.
- `rst_n` — in, 1: reset, asynchronous and active-low.
- `in_valid` — in, 1: `in_data` is valid.
- `in_ready` — out, 1: the block can accept a word.
- `in_data` — in, `WORD_LEN`: input word.
- `in_last` — in, 1: the accepted word closes the frame.
- `terms` — out, `BIT_LEN` × `NUM_ELEMENTS` (unpacked): packed frame, fed directly to the accumulator's `terms`.
- `out_count` — out, `$clog2(NUM_ELEMENTS+1)`: number of loaded slots in the frame.
- `out_valid` — out, 1: `terms` and `out_count` hold a complete frame.
- `out_ready` — in, 1: the consumer has taken the frame; the accumulator sum is registered on this cycle.

## Operation
- Two states, FILL and HOLD. Reset enters FILL with `idx` = 0, all `terms` = 0, `out_count` = 0, `out_valid` = 0.
- FILL:
  - `in_ready` = 1, `out_valid` = 0.
  - A word is accepted when `in_valid && in_ready`.
  - On acceptance, `terms[idx]` ← zero-extended `in_data` and `idx` increments.
  - FILL → HOLD when a word is accepted with `idx == NUM_ELEMENTS-1` or with `in_last` = 1. On that transition `out_count` ← `idx+1`.
- HOLD:
  - `in_ready` = 0, `out_valid` = 1.
  - `terms` and `out_count` do not change.
  - `in_valid` is ignored; no word is consumed.
  - HOLD → FILL on `out_ready` = 1: all `terms` cleared to 0, `idx` ← 0, `out_count` ← 0.
- `in_last` on the final slot is harmless: same transition.
- `in_last` with `in_valid` = 0 has no effect.
- Slots at index ≥ `out_count` are always 0 while `out_valid` = 1.
- Width rule: every entry is `{ {(BIT_LEN-WORD_LEN){1'b0}}, word }`. The sum of `NUM_ELEMENTS` maximal words therefore fits in `BIT_LEN`.
- Reset mid-frame: any partial frame is discarded. After `rst_n` deasserts, the block is in FILL, empty, with `idx` = 0.

## Timing
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `out_ready` or `in_valid`.
- Fill latency:
  - The word accepted in cycle t closing the frame gives `out_valid` = 1 in cycle t+1.
- Release latency:
  - A handshake in cycle h gives `in_ready` = 1 in cycle h+1.
  - The first word of the next frame can be accepted in h+1.
- Throughput: one full frame per `NUM_ELEMENTS`+1 cycles at best.
- `terms` change only on accepted input or on the HOLD → FILL transition.

## Structure
- Shared package `accumulator_pkg` holds:
  - the state enum typedef (FILL, HOLD);
  - a function computing `BIT_LEN` from `WORD_LEN` and `NUM_ELEMENTS`, so that producer and consumer agree on the width.
- Single flat module: the `idx` counter, state register and term buffer are inline. No sub-module.
- The testbench instantiates `accumulator` downstream with the same `NUM_ELEMENTS` and `BIT_LEN` to check sums.

## Test plan
All cases use defaults, `BIT_LEN` = 20.
1. Words 1..9 on consecutive cycles, `out_ready` = 1 → `out_valid` one cycle after the 9th word; `out_count` = 9; `terms[k]` = k+1; accumulator S = 45; `in_ready` back high the next cycle.
2. Nine words of 0xFFFF → each `terms` entry = 0x0FFFF; S = 0x8FFF7, with no truncation.
3. Words 5, 6, 7 with `in_last` on 7 → `out_count` = 3; `terms[3..8]` = 0; S = 18.
4. Backpressure: frame complete, `out_ready` low for 5 cycles, `in_valid` held high with data 0xAAAA → `in_ready` = 0 throughout; `terms` unchanged; 0xAAAA is accepted as `terms[0]` of the next frame in the cycle after the handshake.
5. Reset pulse after 4 of 9 words → `out_valid` = 0, `in_ready` = 0 during reset; after release, a full frame 10..18 yields S = 126 with no stale slots.
6. Single word 0x1234 with `in_last` → `out_count` = 1; S = 0x01234.
